// File: rtl/g_3arb_rr_if.sv
// Request/grant bundle between requester macros and the 3-way arbiter.
// master = requester side, slave = arbiter side.
interface g_3arb_rr_if;
   logic [2:0] REQ;
   logic [2:0] GNT;
   logic [1:0] OWNER;
   logic       BUSY;
   logic       TMO;

   modport master (
      output REQ,
      input  GNT,
      input  OWNER,
      input  BUSY,
      input  TMO
   );

   modport slave (
      input  REQ,
      output GNT,
      output OWNER,
      output BUSY,
      output TMO
   );
endinterface

// File: rtl/g_3arb_rr.sv
// Three-requester round-robin arbiter, registered one-hot grant, one dead cycle per handoff.
// Define G_3ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles under contention.
module g_3arb_rr #(
   parameter int MAX_HOLD = 8
) (
   input  logic        CK,
   input  logic        CDN,
   g_3arb_rr_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   if (MAX_HOLD < 2) begin : g_bad_hold
      $error("g_3arb_rr: MAX_HOLD must be >= 2");
   end

   state_t     state_q;
   logic [1:0] last_q;
   logic [2:0] gnt_q;
   logic [1:0] owner_q;
   logic       busy_q;

   logic [1:0] o1;
   logic [1:0] o2;
   logic [1:0] win;
   logic       any_req;
   logic       own_req;

   // Search order LAST+1, LAST+2, LAST; lower-priority candidates are overwritten.
   always_comb begin
      o1  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
      o2  = (o1 == 2'd2) ? 2'd0 : o1 + 2'd1;
      win = last_q;
      if (bus.REQ[o2]) win = o2;
      if (bus.REQ[o1]) win = o1;
   end

   assign any_req = |bus.REQ;
   assign own_req = |(gnt_q & bus.REQ);

`ifdef G_3ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD);
   localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);

   logic [CW-1:0] cnt_q;
   logic          tmo_q;
   logic          other;

   assign other = |(bus.REQ & ~gnt_q);
`endif

   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         state_q <= IDLE;
         last_q  <= 2'd2;
         gnt_q   <= 3'b000;
         owner_q <= 2'b11;
         busy_q  <= 1'b0;
`ifdef G_3ARB_TIMEOUT_EN
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
`ifdef G_3ARB_TIMEOUT_EN
         tmo_q <= 1'b0;
`endif
         unique case (state_q)
            IDLE, GAP: begin
               if (any_req) begin
                  state_q <= GRANT;
                  gnt_q   <= 3'(3'b001 << win);
                  owner_q <= win;
                  busy_q  <= 1'b1;
                  last_q  <= win;
`ifdef G_3ARB_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            GRANT: begin
               if (!own_req) begin
                  state_q <= GAP;
                  gnt_q   <= 3'b000;
                  owner_q <= 2'b11;
                  busy_q  <= 1'b0;
`ifdef G_3ARB_TIMEOUT_EN
               end else if (cnt_q == CMAX && other) begin
                  state_q <= GAP;
                  gnt_q   <= 3'b000;
                  owner_q <= 2'b11;
                  busy_q  <= 1'b0;
                  tmo_q   <= 1'b1;
               end else if (cnt_q != CMAX) begin
                  cnt_q   <= cnt_q + 1'b1;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= 3'b000;
               owner_q <= 2'b11;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.GNT   = gnt_q;
   assign bus.OWNER = owner_q;
   assign bus.BUSY  = busy_q;
`ifdef G_3ARB_TIMEOUT_EN
   assign bus.TMO   = tmo_q;
`else
   assign bus.TMO   = 1'b0;
`endif

endmodule

// File: tb/tb_g_3arb_rr.sv
// Bench for g_3arb_rr: vector table, corner sequences, random run vs. a rule-level model.
// Honours G_3ARB_TIMEOUT_EN the same way as the design.
module tb_g_3arb_rr;

   localparam int HOLD = 4;
`ifdef G_3ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic CK;
   logic CDN;

   g_3arb_rr_if bif ();

   g_3arb_rr #(.MAX_HOLD(HOLD)) dut (
      .CK  (CK),
      .CDN (CDN),
      .bus (bif)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   int n_chk;
   int n_pass;

   // Model state: current owner (-1 none), last winner, cycles held, timeout pulse.
   int m_own;
   int m_last;
   int m_hold;
   bit m_tmo;

   typedef struct {
      logic [2:0] req;
      logic [2:0] gnt;
      logic [1:0] own;
      logic       busy;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic m_reset();
      m_own  = -1;
      m_last = 2;
      m_hold = 0;
      m_tmo  = 1'b0;
   endtask

   task automatic m_step(input logic [2:0] r);
      m_tmo = 1'b0;
      if (m_own < 0) begin
         for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_last + k) % 3;
            if (m_own < 0 && r[idx]) begin
               m_own  = idx;
               m_last = idx;
               m_hold = 0;
            end
         end
      end else if (!r[m_own]) begin
         m_own = -1;
      end else if (TMO_EN && m_hold >= HOLD - 1 &&
                   (r & ~(3'b001 << m_own)) != 3'b000) begin
         m_own = -1;
         m_tmo = 1'b1;
      end else begin
         m_hold++;
      end
   endtask

   function automatic logic [6:0] m_outs();
      logic [2:0] g;
      logic [1:0] o;
      g = (m_own < 0) ? 3'b000 : 3'(3'b001 << m_own);
      o = (m_own < 0) ? 2'b11 : 2'(m_own);
      return {g, o, m_own >= 0, m_tmo};
   endfunction

   function automatic logic [6:0] dut_outs();
      return {bif.GNT, bif.OWNER, bif.BUSY, bif.TMO};
   endfunction

   // Apply REQ for one cycle, advance the model, sample 1 time unit after the edge.
   task automatic cyc(input logic [2:0] r, input string name);
      bif.REQ = r;
      @(posedge CK);
      m_step(r);
      #1;
      chk(name, dut_outs(), m_outs());
   endtask

   task automatic do_reset();
      bif.REQ = 3'b000;
      CDN = 1'b0;
      #2;
      chk("reset_state", dut_outs(), {3'b000, 2'b11, 1'b0, 1'b0});
      @(posedge CK);
      #1;
      CDN = 1'b1;
      m_reset();
   endtask

   logic [2:0] r;
   logic [2:0] prev_g;
   int         order [$];
   int         gcyc;
   int         tmo_n;

   initial begin
      n_chk  = 0;
      n_pass = 0;
      CDN    = 1'b1;
      bif.REQ = 3'b000;
      m_reset();

      vt[0]  = '{3'b100, 3'b100, 2'd2, 1'b1};
      vt[1]  = '{3'b100, 3'b100, 2'd2, 1'b1};
      vt[2]  = '{3'b000, 3'b000, 2'd3, 1'b0};
      vt[3]  = '{3'b000, 3'b000, 2'd3, 1'b0};
      vt[4]  = '{3'b111, 3'b001, 2'd0, 1'b1};
      vt[5]  = '{3'b111, 3'b001, 2'd0, 1'b1};
      vt[6]  = '{3'b110, 3'b000, 2'd3, 1'b0};
      vt[7]  = '{3'b110, 3'b010, 2'd1, 1'b1};
      vt[8]  = '{3'b101, 3'b000, 2'd3, 1'b0};
      vt[9]  = '{3'b101, 3'b100, 2'd2, 1'b1};
      vt[10] = '{3'b001, 3'b000, 2'd3, 1'b0};
      vt[11] = '{3'b001, 3'b001, 2'd0, 1'b1};
      vt[12] = '{3'b000, 3'b000, 2'd3, 1'b0};
      vt[13] = '{3'b000, 3'b000, 2'd3, 1'b0};

      #3;
      do_reset();

      // Latency, gap, fairness vectors from a fresh reset.
      for (int i = 0; i < 14; i++) begin
         bif.REQ = vt[i].req;
         @(posedge CK);
         #1;
         chk($sformatf("vec%0d", i), dut_outs(),
             {vt[i].gnt, vt[i].own, vt[i].busy, 1'b0});
      end

      // Async reset mid-grant, then requester 0 first.
      do_reset();
      cyc(3'b100, "t1_grant");
      #3;
      CDN = 1'b0;
      #1;
      chk("t1_async", dut_outs(), {3'b000, 2'b11, 1'b0, 1'b0});
      @(posedge CK);
      #1;
      CDN = 1'b1;
      m_reset();
      cyc(3'b111, "t1_after");
      chk("t1_first", bif.GNT, 3'b001);

      // Rotation: each owner drops for one cycle after 3 granted cycles.
      do_reset();
      prev_g = 3'b000;
      gcyc   = 0;
      order.delete();
      for (int c = 0; c < 24; c++) begin
         r = 3'b111;
         if (m_own >= 0 && gcyc == 3) r[m_own] = 1'b0;
         cyc(r, "t2_rot");
         if (m_own >= 0) gcyc++;
         else gcyc = 0;
         chk("t2_no_overlap",
             (prev_g != 3'b000 && bif.GNT != 3'b000 && prev_g != bif.GNT),
             1'b0);
         if (bif.GNT != 3'b000 && prev_g == 3'b000)
            order.push_back(int'(bif.OWNER));
         prev_g = bif.GNT;
      end
      chk("t2_len", (order.size() >= 4), 1'b1);
      if (order.size() >= 4)
         chk("t2_order", {order[0][1:0], order[1][1:0],
                          order[2][1:0], order[3][1:0]},
             {2'd0, 2'd1, 2'd2, 2'd0});

      // Two contenders held: forced release only in the timeout build.
      do_reset();
      tmo_n = 0;
      for (int c = 1; c <= 8; c++) begin
         cyc(3'b011, "t5_seq");
         if (bif.TMO) tmo_n++;
         if (c == 5) chk("t5_tmo_pulse", bif.TMO, TMO_EN);
         if (c == 6) chk("t5_next_owner", bif.GNT,
                         TMO_EN ? 3'b010 : 3'b001);
      end
      chk("t5_tmo_count", tmo_n, TMO_EN ? 1 : 0);

      // No contender: grant is kept and never times out.
      do_reset();
      tmo_n = 0;
      for (int c = 0; c < 20; c++) begin
         cyc(3'b001, "t6_seq");
         if (bif.TMO) tmo_n++;
      end
      chk("t6_gnt", bif.GNT, 3'b001);
      chk("t6_tmo", tmo_n, 0);

      // Random requests that tend to persist for a few cycles.
      do_reset();
      r = 3'b000;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
         cyc(r, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
